// File: rtl/sdram_req_queue.sv
// sdram_req_queue: FIFO-buffered request front-end issuing one operation at a time to the SDRAM controller
module sdram_req_queue #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        ctrl_cmd,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_ready,
    input  logic              ctrl_valid,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic [DATA_W-1:0] ctrl_rdata,
    output logic [7:0]        timeout_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WBUSY = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              op_we_q, op_we_d;
    logic [1:0]        ctrl_cmd_q, ctrl_cmd_d;
    logic [ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [DATA_W-1:0] ctrl_wdata_q, ctrl_wdata_d;
    logic              ctrl_ready_q, ctrl_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic [EW-1:0]     head;
    logic              full, empty, push, pop;

    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign empty = wr_q == rd_q;
    assign head  = mem_q[rd_q[PW-1:0]];
    assign push  = req_valid && !full;
    assign pop   = state_q == S_IDLE && !empty && ctrl_valid && !rsp_valid_q;

    assign req_ready   = !full;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign ctrl_cmd    = ctrl_cmd_q;
    assign ctrl_addr   = ctrl_addr_q;
    assign ctrl_ready  = ctrl_ready_q;
    assign ctrl_wdata  = ctrl_wdata_q;
    assign timeout_cnt = tcnt_q;

    // Next-state logic: FIFO pointers plus the single-outstanding-operation sequencer
    always_comb begin
        wr_d         = wr_q + (PW+1)'(push);
        rd_d         = rd_q + (PW+1)'(pop);
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_we_d      = op_we_q;
        ctrl_cmd_d   = ctrl_cmd_q;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdata_d = ctrl_wdata_q;
        ctrl_ready_d = ctrl_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        tcnt_d       = tcnt_q;
        case (state_q)
            S_IDLE: if (pop) begin
                state_d      = S_ISSUE;
                op_we_d      = head[EW-1];
                ctrl_cmd_d   = head[EW-1] ? 2'b10 : 2'b01;
                ctrl_addr_d  = head[EW-2:DATA_W];
                ctrl_wdata_d = head[DATA_W-1:0];
                ctrl_ready_d = 1'b1;
            end
            S_ISSUE: begin
                state_d      = S_WBUSY;
                ctrl_ready_d = 1'b0;
                cnt_d        = '0;
            end
            S_WBUSY: if (!ctrl_valid) begin
                state_d = S_WDONE;
                cnt_d   = '0;
            end else if (cnt_q == TMO) begin
                state_d    = S_ABORT;
                ctrl_cmd_d = 2'b00;
            end else cnt_d = cnt_q + CW'(1);
            S_WDONE: if (ctrl_valid) begin
                ctrl_cmd_d  = 2'b00;
                state_d     = op_we_q ? S_IDLE : S_RESP;
                rsp_valid_d = !op_we_q;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = op_we_q ? rsp_rdata_q : ctrl_rdata;
            end else if (cnt_q == TMO) begin
                state_d    = S_ABORT;
                ctrl_cmd_d = 2'b00;
            end else cnt_d = cnt_q + CW'(1);
            S_RESP: if (rsp_ready) begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
            S_ABORT: begin
                tcnt_d      = tcnt_q + 8'(tcnt_q != 8'hFF);
                state_d     = op_we_q ? S_IDLE : S_RESP;
                rsp_valid_d = !op_we_q;
                rsp_err_d   = !op_we_q;
                rsp_rdata_d = op_we_q ? rsp_rdata_q : '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PW-1:0]] <= {req_we, req_addr, req_wdata};
    end

    // State registers; reset abandons any operation in flight and empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q         <= '0;
            rd_q         <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_we_q      <= 1'b0;
            ctrl_cmd_q   <= 2'b00;
            ctrl_addr_q  <= '0;
            ctrl_wdata_q <= '0;
            ctrl_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            tcnt_q       <= '0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_we_q      <= op_we_d;
            ctrl_cmd_q   <= ctrl_cmd_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_wdata_q <= ctrl_wdata_d;
            ctrl_ready_q <= ctrl_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            tcnt_q       <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_sdram_req_queue.sv
// tb_sdram_req_queue: directed scoreboard bench with a behavioural SDRAM controller responder
module tb_sdram_req_queue;
    localparam int NORMAL = 0, STALL = 1, HANG = 2, NORET = 3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [24:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [15:0] rsp_rdata;
    logic [1:0]  ctrl_cmd;
    logic [24:0] ctrl_addr;
    logic        ctrl_ready, ctrl_valid = 1'b1;
    logic [15:0] ctrl_wdata, ctrl_rdata = '0;
    logic [7:0]  timeout_cnt;

    int checks = 0, failures = 0;
    int mode = NORMAL;
    logic [26:0] exp_cmd [$];
    logic [16:0] sb [$];
    logic [15:0] emem [logic [24:0]];
    logic [15:0] cmem [logic [24:0]];

    sdram_req_queue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ctrl_cmd(ctrl_cmd), .ctrl_addr(ctrl_addr), .ctrl_ready(ctrl_ready),
        .ctrl_valid(ctrl_valid), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [24:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [24:0] a);
        return emem.exists(a) ? emem[a] : dflt(a);
    endfunction

    // Controller responder: accepts a strobe, drops valid for a few cycles, then completes
    logic [1:0]  cur_cmd;
    logic [24:0] cur_addr;
    logic [15:0] cur_wd;
    logic [26:0] ce;
    bit          pending = 0;
    int          bcnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            pending = 0;
            ctrl_valid = 1'b1;
        end else if (pending) begin
            chk("ctrl_ready_pulse", ctrl_ready, 0);
            chk("ctrl_cmd_hold", ctrl_cmd, cur_cmd);
            chk("ctrl_addr_hold", ctrl_addr, cur_addr);
            chk("ctrl_wdata_hold", ctrl_wdata, cur_wd);
            if (mode != NORET) begin
                if (bcnt == 0) begin
                    ctrl_valid = 1'b1;
                    ctrl_rdata = cmem.exists(cur_addr) ? cmem[cur_addr] : dflt(cur_addr);
                    pending = 0;
                end else bcnt--;
            end
        end else if (ctrl_ready) begin
            chk("issue_expected", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) begin
                ce = exp_cmd.pop_front();
                chk("issue_cmd", ctrl_cmd, ce[26:25]);
                chk("issue_addr", ctrl_addr, ce[24:0]);
            end
            cur_cmd = ctrl_cmd;
            cur_addr = ctrl_addr;
            cur_wd = ctrl_wdata;
            if (ctrl_cmd == 2'b10) cmem[ctrl_addr] = ctrl_wdata;
            if (mode != HANG) begin
                pending = 1;
                bcnt = 2;
                ctrl_valid = 1'b0;
            end
        end else ctrl_valid = (mode != STALL);
    end

    // Response monitor: every accepted response must match the scoreboard head
    logic [16:0] se;
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            chk("rsp_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                se = sb.pop_front();
                chk("rsp_err", rsp_err, se[16]);
                chk("rsp_rdata", rsp_rdata, se[15:0]);
            end
        end
    end

    task automatic push(input logic we, input logic [24:0] a, input logic [15:0] d, input logic err);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("push_ready", req_ready, 1);
        exp_cmd.push_back({we ? 2'b10 : 2'b01, a});
        if (we) emem[a] = d;
        else sb.push_back({err, err ? 16'h0 : exp_rd(a)});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || exp_cmd.size() != 0 || ctrl_cmd != 2'b00 || rsp_valid) && n < 300) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        chk(tag, sb.size() + exp_cmd.size(), 0);
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ctrl_cmd", ctrl_cmd, 0);
        chk("rst_ctrl_addr", ctrl_addr, 0);
        chk("rst_ctrl_ready", ctrl_ready, 0);
        chk("rst_ctrl_wdata", ctrl_wdata, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmem[25'h0A5_5C3] = 16'hBEEF;
        emem[25'h0A5_5C3] = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1 rst = 1'b0;

        push(1'b0, 25'h0A5_5C3, 16'h0, 1'b0);
        drain("drain_beef");

        push(1'b1, 25'h1FF_FFFF, 16'h1234, 1'b0);
        push(1'b0, 25'h1FF_FFFF, 16'h0, 1'b0);
        drain("drain_wr_rd");
        chk("no_rsp_after_write", rsp_valid, 0);

        @(posedge clk); #1 mode = STALL;
        push(1'b1, 25'h012_3456, 16'hCAFE, 1'b0);
        push(1'b0, 25'h012_3456, 16'h0, 1'b0);
        push(1'b0, 25'h100_0001, 16'h0, 1'b0);
        push(1'b0, 25'h0F0_0F0F, 16'h0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h155_5555;
        @(negedge clk);
        chk("req_ready_full", req_ready, 0);
        chk("stall_no_issue", exp_cmd.size(), 4);
        @(posedge clk); #1;
        req_valid = 1'b0; mode = NORMAL;
        drain("drain_fifo_order");

        mode = HANG;
        push(1'b0, 25'h0AA_AAAA, 16'h0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
        chk("abort_latency", n, 19);
        chk("abort_err", rsp_err, 1);
        drain("drain_abort");
        chk("timeout_cnt_1", timeout_cnt, 1);
        mode = NORMAL;

        rsp_ready = 1'b0;
        push(1'b0, 25'h000_0010, 16'h0, 1'b0);
        push(1'b0, 25'h000_0020, 16'h0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
        repeat (20) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, sb[0][15:0]);
            chk("bp_no_issue", exp_cmd.size(), 1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        drain("drain_backpressure");

        mode = NORET;
        push(1'b0, 25'h000_0100, 16'h0, 1'b0);
        push(1'b0, 25'h000_0200, 16'h0, 1'b0);
        push(1'b0, 25'h000_0300, 16'h0, 1'b0);
        push(1'b0, 25'h000_0400, 16'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_busy", ctrl_cmd, 2'b01);
        @(posedge clk); #1;
        rst = 1'b1; mode = NORMAL;
        exp_cmd.delete();
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_idle", ctrl_ready, 0);
        end
        chk("post_rst_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
